// File: rtl/pc_sequencer.sv
// pc_sequencer -- program-counter sequencer with a return-address stack.
//
// Each rising edge executes one op: sequential step, absolute jump, relative
// branch, branch-to-subroutine (pushes the return address), or return (pops
// it). Stack overflow and underflow raise sticky flags. A push onto a full
// stack is dropped, and a pop from an empty stack falls through to pc+1.
//
// Optional feature (macro PCSEQ_IRQ_EN): level interrupt input `irq` and an
// internal enable bit. A taken interrupt pushes the current pc, jumps to
// IRQ_VECTOR and disables further interrupts. RETI re-enables them.
//
// Ports:
//   clk        rising-edge clock
//   nreset     asynchronous active-low reset
//   stall      holds all state and ignores op/cond/irq/clr_flags
//   op[2:0]    0 NEXT, 1 JMP, 2 BRA, 3 BSR, 4 RET, 5 RETI, 6-7 NEXT
//   cond       take condition for JMP/BRA/BSR
//   target     absolute address (JMP) or two's-complement offset (BRA/BSR)
//   clr_flags  clears the sticky flags (a same-cycle setting event wins)
//   irq        interrupt request level (PCSEQ_IRQ_EN only)
//   pc         registered program counter
//   sp         number of valid stack entries
//   stack_ovf  sticky push-while-full flag
//   stack_unf  sticky pop-while-empty flag
module pc_sequencer #(
  parameter int PC_W        = 11,
  parameter int STACK_DEPTH = 4,
  parameter int RESET_PC    = 0,
  parameter int IRQ_VECTOR  = 1
) (
  input  logic                             clk,
  input  logic                             nreset,
  input  logic                             stall,
  input  logic [2:0]                       op,
  input  logic                             cond,
  input  logic [PC_W-1:0]                  target,
  input  logic                             clr_flags,
`ifdef PCSEQ_IRQ_EN
  input  logic                             irq,
`endif
  output logic [PC_W-1:0]                  pc,
  output logic [$clog2(STACK_DEPTH+1)-1:0] sp,
  output logic                             stack_ovf,
  output logic                             stack_unf
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [2:0] OP_NEXT = 3'd0;
  localparam logic [2:0] OP_JMP  = 3'd1;
  localparam logic [2:0] OP_BRA  = 3'd2;
  localparam logic [2:0] OP_BSR  = 3'd3;
  localparam logic [2:0] OP_RET  = 3'd4;
  localparam logic [2:0] OP_RETI = 3'd5;

  localparam logic [PC_W-1:0] PC_ONE   = PC_W'(1);
  localparam logic [PC_W-1:0] PC_RESET = PC_W'(RESET_PC);
  localparam logic [PC_W-1:0] PC_IRQ   = PC_W'(IRQ_VECTOR);
  localparam logic [SP_W-1:0] SP_ONE   = SP_W'(1);
  localparam logic [SP_W-1:0] SP_ZERO  = SP_W'(0);
  localparam logic [SP_W-1:0] SP_FULL  = SP_W'(STACK_DEPTH);

  logic [PC_W-1:0] pc_r;
  logic [SP_W-1:0] sp_r;
  logic            ovf_r;
  logic            unf_r;
  logic [PC_W-1:0] stack_r [STACK_DEPTH];

  logic [PC_W-1:0] pc_inc_s;
  logic [PC_W-1:0] pc_rel_s;
  logic [SP_W-1:0] sp_dec_s;
  logic [PC_W-1:0] top_s;
  logic            full_s;
  logic            empty_s;
  logic            irq_take_s;

  logic [PC_W-1:0] pc_nxt_s;
  logic [SP_W-1:0] sp_nxt_s;
  logic            push_en_s;
  logic [PC_W-1:0] push_data_s;
  logic            ovf_set_s;
  logic            unf_set_s;
  logic            ovf_nxt_s;
  logic            unf_nxt_s;

  assign pc_inc_s = pc_r + PC_ONE;
  assign pc_rel_s = pc_r + target;
  assign sp_dec_s = sp_r - SP_ONE;
  assign top_s    = stack_r[sp_dec_s[IDX_W-1:0]];
  assign full_s   = (sp_r == SP_FULL);
  assign empty_s  = (sp_r == SP_ZERO);

`ifdef PCSEQ_IRQ_EN
  logic ie_r;
  logic ie_nxt_s;

  // Interrupts are held off while the stack is full so no return address is lost.
  assign irq_take_s = irq & ie_r & ~full_s & ~stall;

  // Enable bit: cleared on interrupt entry, set by any RETI (even on underflow).
  always_comb begin
    ie_nxt_s = ie_r;
    if (stall) begin
      ie_nxt_s = ie_r;
    end else if (irq_take_s) begin
      ie_nxt_s = 1'b0;
    end else if (op == OP_RETI) begin
      ie_nxt_s = 1'b1;
    end else begin
      ie_nxt_s = ie_r;
    end
  end

  // Interrupt enable register.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      ie_r <= 1'b1;
    end else begin
      ie_r <= ie_nxt_s;
    end
  end
`else
  assign irq_take_s = 1'b0;
`endif

  // Next-state decode for pc, sp and stack push/pop.
  always_comb begin
    pc_nxt_s    = pc_r;
    sp_nxt_s    = sp_r;
    push_en_s   = 1'b0;
    push_data_s = pc_inc_s;
    ovf_set_s   = 1'b0;
    unf_set_s   = 1'b0;
    if (stall) begin
      pc_nxt_s = pc_r;
    end else if (irq_take_s) begin
      // The interrupted instruction is not executed, so its own pc is saved.
      push_en_s   = 1'b1;
      push_data_s = pc_r;
      sp_nxt_s    = sp_r + SP_ONE;
      pc_nxt_s    = PC_IRQ;
    end else begin
      pc_nxt_s = pc_inc_s;
      case (op)
        OP_NEXT: pc_nxt_s = pc_inc_s;
        OP_JMP: begin
          if (cond) pc_nxt_s = target;
          else      pc_nxt_s = pc_inc_s;
        end
        OP_BRA: begin
          if (cond) pc_nxt_s = pc_rel_s;
          else      pc_nxt_s = pc_inc_s;
        end
        OP_BSR: begin
          if (cond && !full_s) begin
            push_en_s = 1'b1;
            sp_nxt_s  = sp_r + SP_ONE;
            pc_nxt_s  = pc_rel_s;
          end else if (cond) begin
            ovf_set_s = 1'b1;
            pc_nxt_s  = pc_inc_s;
          end else begin
            pc_nxt_s = pc_inc_s;
          end
        end
        OP_RET, OP_RETI: begin
          if (!empty_s) begin
            sp_nxt_s = sp_dec_s;
            pc_nxt_s = top_s;
          end else begin
            unf_set_s = 1'b1;
            pc_nxt_s  = pc_inc_s;
          end
        end
        default: pc_nxt_s = pc_inc_s;
      endcase
    end
  end

  // Sticky flags: a same-cycle setting event overrides clr_flags.
  always_comb begin
    ovf_nxt_s = ovf_r;
    unf_nxt_s = unf_r;
    if (stall) begin
      ovf_nxt_s = ovf_r;
      unf_nxt_s = unf_r;
    end else begin
      ovf_nxt_s = (ovf_r & ~clr_flags) | ovf_set_s;
      unf_nxt_s = (unf_r & ~clr_flags) | unf_set_s;
    end
  end

  // Architectural state registers.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      pc_r  <= PC_RESET;
      sp_r  <= SP_ZERO;
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
    end else begin
      pc_r  <= pc_nxt_s;
      sp_r  <= sp_nxt_s;
      ovf_r <= ovf_nxt_s;
      unf_r <= unf_nxt_s;
    end
  end

  // Return-address storage; entries at or above sp are don't-care, so no reset.
  always_ff @(posedge clk) begin
    if (push_en_s) begin
      stack_r[sp_r[IDX_W-1:0]] <= push_data_s;
    end
  end

  assign pc        = pc_r;
  assign sp        = sp_r;
  assign stack_ovf = ovf_r;
  assign stack_unf = unf_r;

endmodule
